// File: rtl/serial_operand_pair_serializer.sv
// Parallel-to-serial front end for the serial comparators: takes an operand pair
// over valid/ready and shifts both words out in lock-step, one bit per clock.
module serial_operand_pair_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    output logic             up_ready,
    output logic             comp_restart,
    output logic             ser_valid,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_first,
    output logic             ser_last
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shift_a, shift_b;
    logic [CW-1:0]    cnt;
    logic             at_last;
    logic             accept;

    // A new pair may be taken on the last bit of the current word, so
    // back-to-back words leave no gap on the serial lines.
    assign at_last      = (state == SHIFT) && (cnt == LAST);
    assign up_ready     = !rst && ((state == IDLE) || at_last);
    assign accept       = up_valid && up_ready;
    assign comp_restart = accept;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = SHIFT;
        end else if (at_last) begin
            state_next = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the shift registers are cleared on reset so idle outputs are
    // defined zeros rather than stale data from an aborted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            cnt     <= '0;
        end else if (accept) begin
            shift_a <= up_a;
            shift_b <= up_b;
            cnt     <= '0;
        end else if (state == SHIFT) begin
            if (MSB_FIRST) begin
                shift_a <= shift_a << 1;
                shift_b <= shift_b << 1;
            end else begin
                shift_a <= shift_a >> 1;
                shift_b <= shift_b >> 1;
            end
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        ser_valid = 1'b0;
        ser_a     = 1'b0;
        ser_b     = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        if (state == SHIFT) begin
            ser_valid = 1'b1;
            ser_a     = MSB_FIRST ? shift_a[WIDTH-1] : shift_a[0];
            ser_b     = MSB_FIRST ? shift_b[WIDTH-1] : shift_b[0];
            ser_first = (cnt == '0);
            ser_last  = (cnt == LAST);
        end
    end

endmodule

// File: tb/tb_serial_operand_pair_serializer.sv
// Self-checking bench: three serializer configurations (4-bit MSB-first, 4-bit
// LSB-first, 1-bit) compared every cycle against a word-level reference model.
module tb_serial_operand_pair_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_valid;
    logic [3:0] up_a, up_b;

    wire  [2:0] o_rdy, o_rst, o_v, o_a, o_b, o_f, o_l;

    int tests = 0;
    int fails = 0;

    // Reference model state: bits of the current word still to emit.
    int         rem [3];
    logic [3:0] wa  [3];
    logic [3:0] wb  [3];
    int         wid [3] = '{4, 4, 1};
    bit         msb [3] = '{1'b1, 1'b0, 1'b1};
    bit         chk = 1'b0;

    logic [3:0] log_ma, log_mb, log_la, log_lb, log_mf, log_ml;
    int         n_restart, n_valid;

    always #5 clk = ~clk;

    serial_operand_pair_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_a(up_a), .up_b(up_b),
        .up_ready(o_rdy[0]), .comp_restart(o_rst[0]), .ser_valid(o_v[0]),
        .ser_a(o_a[0]), .ser_b(o_b[0]), .ser_first(o_f[0]), .ser_last(o_l[0])
    );

    serial_operand_pair_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_a(up_a), .up_b(up_b),
        .up_ready(o_rdy[1]), .comp_restart(o_rst[1]), .ser_valid(o_v[1]),
        .ser_a(o_a[1]), .ser_b(o_b[1]), .ser_first(o_f[1]), .ser_last(o_l[1])
    );

    serial_operand_pair_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_1 (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_a(up_a[0]), .up_b(up_b[0]),
        .up_ready(o_rdy[2]), .comp_restart(o_rst[2]), .ser_valid(o_v[2]),
        .ser_a(o_a[2]), .ser_b(o_b[2]), .ser_first(o_f[2]), .ser_last(o_l[2])
    );

    task automatic check(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d] t=%0t observed=%b expected=%b", tag, k, $time, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model on the clock edge.
    task automatic cycle(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
        bit acc [3];
        rst = r; up_valid = v; up_a = a; up_b = b;
        #1;
        for (int k = 0; k < 3; k++) begin
            int   i, idx;
            logic e_rdy, e_v, e_a, e_b, e_f, e_l;
            e_rdy  = !r && (rem[k] <= 1);
            acc[k] = v && e_rdy;
            e_v    = (rem[k] > 0);
            e_a = 1'b0; e_b = 1'b0; e_f = 1'b0; e_l = 1'b0;
            if (e_v) begin
                i   = wid[k] - rem[k];
                idx = msb[k] ? (wid[k] - 1 - i) : i;
                e_a = wa[k][idx];
                e_b = wb[k][idx];
                e_f = (i == 0);
                e_l = (rem[k] == 1);
            end
            if (chk) begin
                check("up_ready",     k, {3'b0, o_rdy[k]}, {3'b0, e_rdy});
                check("comp_restart", k, {3'b0, o_rst[k]}, {3'b0, acc[k]});
                check("ser_valid",    k, {3'b0, o_v[k]},   {3'b0, e_v});
                check("ser_a",        k, {3'b0, o_a[k]},   {3'b0, e_a});
                check("ser_b",        k, {3'b0, o_b[k]},   {3'b0, e_b});
                check("ser_first",    k, {3'b0, o_f[k]},   {3'b0, e_f});
                check("ser_last",     k, {3'b0, o_l[k]},   {3'b0, e_l});
            end
        end
        log_ma = {log_ma[2:0], o_a[0]};
        log_mb = {log_mb[2:0], o_b[0]};
        log_la = {log_la[2:0], o_a[1]};
        log_lb = {log_lb[2:0], o_b[1]};
        log_mf = {log_mf[2:0], o_f[0]};
        log_ml = {log_ml[2:0], o_l[0]};
        n_restart += int'(o_rst[0]);
        n_valid   += int'(o_v[0]);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                rem[k] = 0;
            end else if (acc[k]) begin
                rem[k] = wid[k];
                wa[k]  = a;
                wb[k]  = b;
            end else if (rem[k] > 0) begin
                rem[k]--;
            end
        end
        chk = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0; wa[k] = '0; wb[k] = '0;
        end
        n_restart = 0; n_valid = 0;
        rst = 1'b1; up_valid = 1'b0; up_a = '0; up_b = '0;
        @(negedge clk);

        // Reset, then the basic 0110 / 0101 word.
        cycle(1'b1, 1'b0, 4'h0, 4'h0);
        cycle(1'b1, 1'b1, 4'hF, 4'hF);
        cycle(1'b0, 1'b1, 4'b0110, 4'b0101);
        repeat (4) cycle(1'b0, 1'b0, 4'hF, 4'hF);
        check("msb_ser_a_seq", 0, log_ma, 4'b0110);
        check("msb_ser_b_seq", 0, log_mb, 4'b0101);
        check("lsb_ser_a_seq", 1, log_la, 4'b0110);
        check("lsb_ser_b_seq", 1, log_lb, 4'b1010);
        check("msb_first_seq", 0, log_mf, 4'b1000);
        check("msb_last_seq",  0, log_ml, 4'b0001);
        cycle(1'b0, 1'b0, 4'h0, 4'h0);

        // Back-to-back pairs with up_valid held high.
        n_restart = 0; n_valid = 0;
        cycle(1'b0, 1'b1, 4'd3, 4'd3);
        repeat (4) cycle(1'b0, 1'b1, 4'd2, 4'd5);
        repeat (4) cycle(1'b0, 1'b1, 4'd9, 4'd1);
        repeat (4) cycle(1'b0, 1'b0, 4'd0, 4'd0);
        check("b2b_restarts", 0, 4'(n_restart), 4'd3);
        check("b2b_valid_run", 0, 4'(n_valid), 4'd12);

        // Reset during bit 2 of a word, then a clean word.
        cycle(1'b0, 1'b1, 4'b1011, 4'b0010);
        cycle(1'b0, 1'b0, 4'h0, 4'h0);
        cycle(1'b0, 1'b0, 4'h0, 4'h0);
        cycle(1'b1, 1'b1, 4'h7, 4'h7);
        repeat (3) cycle(1'b0, 1'b0, 4'h0, 4'h0);
        cycle(1'b0, 1'b1, 4'b1100, 4'b0011);
        repeat (4) cycle(1'b0, 1'b0, 4'h0, 4'h0);
        check("post_rst_ser_a_seq", 0, log_ma, 4'b1100);

        // Stall: operands change every cycle; only the ser_last value is taken.
        cycle(1'b0, 1'b1, 4'd1, 4'd2);
        for (int j = 0; j < 8; j++) cycle(1'b0, 1'b1, 4'(j + 4), 4'(13 - j));
        repeat (4) cycle(1'b0, 1'b0, 4'h0, 4'h0);

        // Randomized traffic with occasional resets.
        for (int j = 0; j < 400; j++) begin
            cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom), 4'($urandom));
        end
        repeat (5) cycle(1'b0, 1'b0, 4'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_operand_pair_serializer.md
# serial_operand_pair_serializer

Parallel-to-serial front end for the serial comparators. Accepts a pair of WIDTH-bit operands through a valid/ready handshake and shifts them out one bit per clock on two lock-stepped serial lines, MSB-first or LSB-first as configured. It also produces a restart pulse that drives the downstream comparator's synchronous reset, so each word pair is compared from a clean state with no bubble between back-to-back words.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 1
- MSB_FIRST, 1, 1 = most significant bit first; 0 = least significant bit first

- clk  input  1  single clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- up_valid  input  1  operand pair present on up_a/up_b
- up_a  input  WIDTH  operand A
- up_b  input  WIDTH  operand B
- up_ready  output  1  block can accept a pair this cycle
- comp_restart  output  1  one-cycle pulse; wire to the comparator rst (ORed with system rst)
- ser_valid  output  1  ser_a/ser_b carry a valid bit this cycle
- ser_a  output  1  serial bit of operand A; wire to comparator a
- ser_b  output  1  serial bit of operand B; wire to comparator b
- ser_first  output  1  first bit of the word this cycle
- ser_last  output  1  last bit of the word this cycle; comparator result is final this cycle

## Operation
- Two states: IDLE and SHIFT. State holds registered shift_a, shift_b (WIDTH each) and bit counter cnt (clog2(WIDTH+1) bits).
- up_ready = !rst && (state==IDLE || (state==SHIFT && cnt==WIDTH-1)). This is combinational from state, with no dependence on up_valid.
- Accept = up_valid && up_ready. On accept, load up_a/up_b into the shift registers, set cnt=0, go to SHIFT.
- comp_restart = accept (combinational).
  - Asserting the comparator's synchronous reset in the accept cycle clears it for the following cycle, which carries bit 0.
  - When accept coincides with the last bit of the previous word, the comparator outputs for that last bit are still valid in that cycle; only the next state is reset.
- SHIFT state:
  - ser_valid=1.
  - ser_a/ser_b = shift_a/shift_b bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0).
  - ser_first = (cnt==0); ser_last = (cnt==WIDTH-1).
  - Each cycle: shift toward the output end, fill with 0, cnt++.
- At cnt==WIDTH-1: if accept, reload and stay in SHIFT with cnt=0; else go to IDLE.
- IDLE state: ser_valid, ser_a, ser_b, ser_first, ser_last all 0.
- up_a/up_b are sampled only on accept; changes at other times are ignored.
- WIDTH=1: ser_first and ser_last both assert on the single bit cycle; back-to-back accepts every cycle are legal.
- No downstream backpressure. Once accepted, a word is emitted in exactly WIDTH consecutive cycles.

## Timing
- Reset (rst high at a posedge):
  - state=IDLE, cnt=0, shift registers 0.
  - While rst is high: up_ready=0, comp_restart=0.
  - After reset: ser_valid, ser_a, ser_b, ser_first, ser_last all 0.
  - First accept is possible in the first cycle with rst low.
- Accept in cycle k: bit i of the word appears in cycle k+1+i for i=0..WIDTH-1; ser_first in k+1, ser_last in k+WIDTH.
- Accept-to-first-bit latency is 1 cycle. Sustained throughput is one word per WIDTH cycles, with no idle cycle between back-to-back words.
- Reset mid-word: the word is aborted. No further ser_valid until a new accept, and no ser_last is emitted for the aborted word.
- up_valid held high while up_ready=0: no load, no comp_restart, and the current word is unaffected.

## Test plan
- WIDTH=4, MSB_FIRST=1; after reset, present a=4'b0110, b=4'b0101 → ser_a 0,1,1,0 and ser_b 0,1,0,1 on cycles k+1..k+4; ser_first only at k+1, ser_last only at k+4; a comparator fed by this block reads eq,eq,greater,greater.
- Same operands with MSB_FIRST=0 → ser_a 0,1,1,0 and ser_b 1,0,1,0; LSB-first comparator ends greater at k+4.
- Back-to-back: up_valid held high with pairs (3,3),(2,5),(9,1) at WIDTH=4 → up_ready high only in IDLE and on each ser_last cycle; 12 consecutive ser_valid cycles; comp_restart on accept cycles k, k+4, k+8; comparator results equal, less, greater on the respective ser_last cycles.
- Reset mid-word: assert rst during bit 2 of a 4-bit word → outputs 0 from the next cycle, no ser_last; the next accepted pair serializes correctly.
- WIDTH=1 with up_valid held high, a=1,0,1 and b=0,0,1 → one bit per cycle, ser_first=ser_last=1 every cycle, comp_restart every cycle.
- Stall: up_valid high mid-word with operands changing every cycle → only the value present on the ser_last cycle is captured.
